// File: rtl/s2p_pkg.sv
// rtl/s2p_pkg.sv - shared types and constants for the s2p serial receiver
package s2p_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_LATCH = 2'b11
  } state_t;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_TIMEOUT = 1024;

  // Bit counter must hold 0..WIDTH+1 so an over-long frame stays distinguishable
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/s2p_sync_edge.sv
// rtl/s2p_sync_edge.sv - 2-flop synchronizer with rise/fall detect against one extra stage
module sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_prev <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/s2p.sv
// rtl/s2p.sv - oversampling three-wire serial-to-parallel receiver, MSB first
module s2p
  import s2p_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             sdat,
  input  logic             sen,
  input  logic             err_clr,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             err,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic w_sclk_rise, w_sdat, w_sen_fall, w_sen_rise;
  logic w_sclk_sync_unused, w_sclk_fall_unused;
  logic w_sdat_rise_unused, w_sdat_fall_unused, w_sen_sync_unused;

  sync_edge #(.RESET_VAL(1'b1)) u_sclk (
    .clk(clk), .rst(rst), .i_d(sclk),
    .o_sync(w_sclk_sync_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall_unused)
  );

  sync_edge #(.RESET_VAL(1'b0)) u_sdat (
    .clk(clk), .rst(rst), .i_d(sdat),
    .o_sync(w_sdat), .o_rise(w_sdat_rise_unused), .o_fall(w_sdat_fall_unused)
  );

  sync_edge #(.RESET_VAL(1'b1)) u_sen (
    .clk(clk), .rst(rst), .i_d(sen),
    .o_sync(w_sen_sync_unused), .o_rise(w_sen_rise), .o_fall(w_sen_fall)
  );

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_sr, w_sr_nx;
  logic [CW-1:0]    r_bcnt, w_bcnt_nx;
  logic [TW-1:0]    r_tcnt, w_tcnt_nx;
  logic             w_load, w_err_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_sr_nx    = r_sr;
    w_bcnt_nx  = r_bcnt;
    w_tcnt_nx  = r_tcnt;
    w_load     = 1'b0;
    w_err_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sen_fall) begin
          w_state_nx = S_SHIFT;
          w_sr_nx    = '0;
          w_bcnt_nx  = '0;
          w_tcnt_nx  = '0;
        end
      end
      S_SHIFT: begin
        if (w_sclk_rise) begin
          w_sr_nx   = {r_sr[WIDTH-2:0], w_sdat};
          w_tcnt_nx = '0;
          if (r_bcnt != CW'(WIDTH + 1)) w_bcnt_nx = r_bcnt + CW'(1);
        end else begin
          w_tcnt_nx = r_tcnt + TW'(1);
        end
        // The coincident bit is already in w_bcnt_nx when LATCH judges the count
        if (w_sen_rise) begin
          w_state_nx = S_LATCH;
        end else if (!w_sclk_rise && w_tcnt_nx == TW'(TIMEOUT)) begin
          w_state_nx = S_IDLE;
          w_err_set  = 1'b1;
        end
      end
      S_LATCH: begin
        if (r_bcnt == CW'(WIDTH)) w_load = 1'b1;
        else                      w_err_set = 1'b1;
        if (w_sen_fall) begin
          w_state_nx = S_SHIFT;
          w_sr_nx    = '0;
          w_bcnt_nx  = '0;
          w_tcnt_nx  = '0;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr   <= '0;
      r_bcnt <= '0;
      r_tcnt <= '0;
      data   <= '0;
      valid  <= 1'b0;
      err    <= 1'b0;
    end else begin
      r_sr   <= w_sr_nx;
      r_bcnt <= w_bcnt_nx;
      r_tcnt <= w_tcnt_nx;
      valid  <= w_load;
      if (w_load) data <= r_sr;
      if (w_err_set)    err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule
